// File: rtl/gmm_pkg.sv
// Shared constants and helpers for the GMM datapath.
//
// Purpose:
//   Single source for the latencies of the fixed-latency FP IP cores, so the
//   clock-enable stall wrappers and pipe_credit_buffer agree on one value.
//   Also provides the counter-width helper used for occupancy/credit counters.
//
// Contents:
//   FP_MUL_LATENCY  issue-to-result latency of the fp multiplier core
//   FP_ADD_LATENCY  issue-to-result latency of the fp adder core
//   clog2p1(n)      bits needed to hold any value in 0..n
package gmm_pkg;

  localparam int FP_MUL_LATENCY = 11;
  localparam int FP_ADD_LATENCY = 7;

  // Width of a counter that must represent 0..n inclusive (e.g. a credit
  // counter that can reach exactly DEPTH).
  function automatic int clog2p1(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sync_fifo_sa.sv
// Show-ahead single-clock FIFO.
//
// Purpose:
//   Stores results in arrival order. The head entry is presented on rd_data
//   combinationally from the RAM at the registered read pointer, so the
//   consumer sees data in the same cycle it sees !empty. A write is only
//   visible at the head from the cycle after it lands (no bypass).
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset (pointers only; RAM is not reset)
//   wr_en    in   write wr_data at the tail this cycle
//   wr_data  in   DATA_W data to write
//   rd_en    in   drop the head entry this cycle
//   rd_data  out  DATA_W head entry (undefined while empty)
//   empty    out  no entries stored
//   full     out  DEPTH entries stored
//   count    out  number of entries stored, 0..DEPTH
module sync_fifo_sa #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  // Extra MSB on each pointer distinguishes full from empty when the low
  // address bits coincide.
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;

endmodule

// File: rtl/pipe_credit_buffer.sv
// Credit-gated output buffer for a free-running fixed-latency pipeline.
//
// Purpose:
//   Lets a never-stalled FP core (clk_en tied high) feed a backpressured
//   valid/ready stream. Every operand issued into the core is tracked by a
//   valid shift register; its result is caught in a show-ahead FIFO when the
//   tracked valid emerges. A credit counter (in-flight + stored) only admits
//   an operand when a FIFO slot is already guaranteed for its result, so the
//   FIFO can never overflow even though the core cannot be stopped.
//
// Handshake: both the sink and source side use strict valid/ready. A
//   transfer happens in a cycle where valid and ready are both 1 at the
//   rising edge. A valid source holds its data stable until the transfer;
//   ready never depends on the valid of the same interface (snk_ready comes
//   from registered state only; src_valid likewise).
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-high reset (also the core's aclr)
//   snk_valid   in   upstream operand valid
//   snk_ready   out  upstream may transfer (credit available)
//   pipe_issue  out  operand accepted this cycle; drives core operand capture
//   pipe_data   in   DATA_W core result, sampled when the tracked valid emerges
//   src_ready   in   downstream ready
//   src_valid   out  FIFO head valid
//   src_data    out  DATA_W FIFO head data, 0 while src_valid=0
module pipe_credit_buffer
  import gmm_pkg::*;
#(
  parameter int LATENCY = FP_MUL_LATENCY,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              snk_valid,
  output logic              snk_ready,
  output logic              pipe_issue,
  input  logic [DATA_W-1:0] pipe_data,
  input  logic              src_ready,
  output logic              src_valid,
  output logic [DATA_W-1:0] src_data
);

  localparam int CNT_W = clog2p1(DEPTH);
  localparam int PTR_W = $clog2(DEPTH) + 1;

  // Parameter legality, checked at elaboration.
  if (LATENCY < 1) begin : g_bad_latency
    $error("pipe_credit_buffer: LATENCY must be >= 1");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("pipe_credit_buffer: DEPTH must be a power of two >= 2");
  end
  if (DEPTH < LATENCY + 1) begin : g_bad_throughput
    $error("pipe_credit_buffer: DEPTH must be >= LATENCY+1");
  end

  logic [LATENCY-1:0] vld_sr;
  logic [CNT_W-1:0]   cnt;

  logic               fifo_wr;
  logic               fifo_rd;
  logic [DATA_W-1:0]  fifo_rd_data;
  logic               fifo_empty;
  logic               fifo_full;
  logic [PTR_W-1:0]   fifo_count;

  // Credit check uses only the registered count, so a slot freed by a pop
  // becomes usable from the following cycle, never in the pop cycle itself.
  assign snk_ready  = (cnt < CNT_W'(DEPTH));
  // rst gates the issue so nothing enters the core while it is held in aclr.
  assign pipe_issue = snk_valid & snk_ready & ~rst;

  assign fifo_wr    = vld_sr[LATENCY-1];
  assign fifo_rd    = src_valid & src_ready;

  assign src_valid  = ~fifo_empty;
  // RAM contents are not reset; force a clean zero whenever nothing is stored.
  assign src_data   = fifo_empty ? '0 : fifo_rd_data;

  // Tracked valid: bit k set means the operand issued k+1 cycles ago is in
  // flight; the top bit marks pipe_data as a real result this cycle.
  if (LATENCY == 1) begin : g_sr_one
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_sr <= '0;
      end else begin
        vld_sr <= pipe_issue;
      end
    end
  end else begin : g_sr_many
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_sr <= '0;
      end else begin
        vld_sr <= {vld_sr[LATENCY-2:0], pipe_issue};
      end
    end
  end

  // cnt = results in flight + results stored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      case ({pipe_issue, fifo_rd})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  sync_fifo_sa #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_wr),
    .wr_data (pipe_data),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  a_no_write_when_full: assert property (
    @(posedge clk) disable iff (rst) fifo_wr |-> !fifo_full);

  a_no_pop_when_empty: assert property (
    @(posedge clk) disable iff (rst) fifo_rd |-> !fifo_empty);

  a_cnt_bounded: assert property (
    @(posedge clk) disable iff (rst) cnt <= CNT_W'(DEPTH));

  a_cnt_accounts_all: assert property (
    @(posedge clk) disable iff (rst)
      ($countones(vld_sr) + int'(fifo_count)) == int'(cnt));

endmodule

// File: tb/tb_pipe_credit_buffer.sv
// Bench for pipe_credit_buffer: a fixed-latency core model feeds pipe_data,
// a transaction-level scoreboard predicts handshakes and result order, and
// one task per scenario adds its own targeted checks.
module tb_pipe_credit_buffer;

  localparam int LATENCY = 11;
  localparam int DATA_W  = 32;
  localparam int DEPTH   = 16;
  localparam int N_RAND  = 10000;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              snk_valid = 1'b0;
  logic              snk_ready;
  logic              pipe_issue;
  logic [DATA_W-1:0] pipe_data;
  logic              src_ready = 1'b0;
  logic              src_valid;
  logic [DATA_W-1:0] src_data;
  logic [DATA_W-1:0] snk_data = '0;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  pipe_credit_buffer #(
    .LATENCY (LATENCY),
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .snk_valid  (snk_valid),
    .snk_ready  (snk_ready),
    .pipe_issue (pipe_issue),
    .pipe_data  (pipe_data),
    .src_ready  (src_ready),
    .src_valid  (src_valid),
    .src_data   (src_data)
  );

  // ---------------- core model ----------------
  function automatic logic [DATA_W-1:0] core_fn(input logic [DATA_W-1:0] x);
    return (x * 32'h9E37_79B1) ^ 32'h0000_5A5A;
  endfunction

  logic [DATA_W-1:0] core_line [LATENCY];

  // Non-issue cycles push junk so a write at the wrong time shows up as bad data.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) core_line[i] <= '0;
    end else begin
      core_line[0] <= pipe_issue ? core_fn(snk_data) : (32'hBAD0_0000 ^ DATA_W'(cyc));
      for (int i = 1; i < LATENCY; i++) core_line[i] <= core_line[i-1];
    end
  end
  assign pipe_data = core_line[LATENCY-1];

  // ---------------- scoreboard ----------------
  // Model: every accepted operand is owed one result, available LATENCY+1
  // cycles after its issue cycle, delivered in issue order. Outstanding
  // (issued, not yet popped) results may never exceed DEPTH.
  logic [DATA_W-1:0] exp_q[$];
  int                rdy_q[$];
  logic              sb_exp_valid;
  logic              sb_exp_ready;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      rdy_q.delete();
    end else begin
      sb_exp_valid = (exp_q.size() > 0) && (rdy_q[0] <= cyc);
      sb_exp_ready = (exp_q.size() < DEPTH);
      n_checks++;
      if (src_valid !== sb_exp_valid)
        $display("FAIL sb_src_valid cyc=%0d got=%b exp=%b", cyc, src_valid, sb_exp_valid);
      else n_pass++;
      n_checks++;
      if (snk_ready !== sb_exp_ready)
        $display("FAIL sb_snk_ready cyc=%0d got=%b exp=%b", cyc, snk_ready, sb_exp_ready);
      else n_pass++;
      n_checks++;
      if (pipe_issue !== (snk_valid & sb_exp_ready))
        $display("FAIL sb_pipe_issue cyc=%0d got=%b exp=%b", cyc, pipe_issue, snk_valid & sb_exp_ready);
      else n_pass++;
      if (sb_exp_valid && src_ready) begin
        n_checks++;
        if (src_data !== exp_q[0])
          $display("FAIL sb_src_data cyc=%0d got=%h exp=%h", cyc, src_data, exp_q[0]);
        else n_pass++;
        void'(exp_q.pop_front());
        void'(rdy_q.pop_front());
      end
      if (snk_valid && sb_exp_ready) begin
        exp_q.push_back(core_fn(snk_data));
        rdy_q.push_back(cyc + LATENCY + 1);
      end
    end
  end

  // ---------------- driver ----------------
  // Drive one cycle's inputs just after the rising edge, then return at the
  // falling edge of the same cycle so the caller can sample outputs.
  task automatic tick(input logic v, input logic r);
    @(posedge clk);
    #1;
    snk_valid = v;
    src_ready = r;
    snk_data  = $urandom;
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    snk_valid = 1'b1;
    src_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (src_valid !== 1'b0) $display("FAIL reset_src_valid got=%b exp=0", src_valid); else n_pass++;
    n_checks++; if (snk_ready !== 1'b1) $display("FAIL reset_snk_ready got=%b exp=1", snk_ready); else n_pass++;
    n_checks++; if (pipe_issue !== 1'b0) $display("FAIL reset_pipe_issue got=%b exp=0", pipe_issue); else n_pass++;
    n_checks++; if (src_data !== '0) $display("FAIL reset_src_data got=%h exp=0", src_data); else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    snk_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (snk_ready !== 1'b1) $display("FAIL release_snk_ready got=%b exp=1", snk_ready); else n_pass++;
  endtask

  task automatic test_single();
    logic [DATA_W-1:0] op;
    logic [DATA_W-1:0] want;
    tick(1'b0, 1'b1);
    @(posedge clk);
    #1;
    op = $urandom;
    snk_data = op;
    snk_valid = 1'b1;
    src_ready = 1'b1;
    want = core_fn(op);
    @(negedge clk);
    n_checks++; if (pipe_issue !== 1'b1) $display("FAIL single_issue got=%b exp=1", pipe_issue); else n_pass++;
    for (int k = 1; k <= LATENCY + 8; k++) begin
      tick(1'b0, 1'b1);
      n_checks++;
      if (src_valid !== (k == LATENCY + 1))
        $display("FAIL single_valid k=%0d got=%b exp=%b", k, src_valid, k == LATENCY + 1);
      else n_pass++;
      if (k == LATENCY + 1) begin
        n_checks++;
        if (src_data !== want) $display("FAIL single_data got=%h exp=%h", src_data, want);
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int n_valid;
    int first;
    int last;
    int n_drop;
    n_valid = 0;
    first = -1;
    last = -1;
    n_drop = 0;
    for (int k = 0; k < 64 + LATENCY + 10; k++) begin
      tick(k < 64, 1'b1);
      if (k < 64 && snk_ready !== 1'b1) n_drop++;
      if (src_valid === 1'b1) begin
        if (first < 0) first = k;
        last = k;
        n_valid++;
      end
    end
    n_checks++; if (n_drop != 0) $display("FAIL b2b_snk_ready_drops got=%0d exp=0", n_drop); else n_pass++;
    n_checks++; if (n_valid != 64) $display("FAIL b2b_results got=%0d exp=64", n_valid); else n_pass++;
    n_checks++; if (last - first != 63) $display("FAIL b2b_span got=%0d exp=63", last - first); else n_pass++;
    n_checks++; if (first != LATENCY + 1) $display("FAIL b2b_first got=%0d exp=%0d", first, LATENCY + 1); else n_pass++;
  endtask

  task automatic test_fill();
    int n_iss;
    n_iss = 0;
    for (int k = 0; k < 40; k++) begin
      tick(1'b1, 1'b0);
      if (pipe_issue === 1'b1) n_iss++;
    end
    n_checks++; if (n_iss != DEPTH) $display("FAIL fill_issues got=%0d exp=%0d", n_iss, DEPTH); else n_pass++;
    n_checks++; if (snk_ready !== 1'b0) $display("FAIL fill_snk_ready got=%b exp=0", snk_ready); else n_pass++;
    n_checks++; if (src_valid !== 1'b1) $display("FAIL fill_src_valid got=%b exp=1", src_valid); else n_pass++;
  endtask

  task automatic test_pop_one();
    int n_iss;
    tick(1'b1, 1'b1);
    n_checks++; if (snk_ready !== 1'b0) $display("FAIL pop1_ready_same got=%b exp=0", snk_ready); else n_pass++;
    n_checks++; if (pipe_issue !== 1'b0) $display("FAIL pop1_issue_same got=%b exp=0", pipe_issue); else n_pass++;
    tick(1'b1, 1'b0);
    n_checks++; if (snk_ready !== 1'b1) $display("FAIL pop1_ready_next got=%b exp=1", snk_ready); else n_pass++;
    n_checks++; if (pipe_issue !== 1'b1) $display("FAIL pop1_issue_next got=%b exp=1", pipe_issue); else n_pass++;
    n_iss = 0;
    for (int k = 0; k < 10; k++) begin
      tick(1'b1, 1'b0);
      if (pipe_issue === 1'b1) n_iss++;
    end
    n_checks++; if (n_iss != 0) $display("FAIL pop1_extra_issues got=%0d exp=0", n_iss); else n_pass++;
    for (int k = 0; k < 40; k++) tick(1'b0, 1'b1);
    n_checks++; if (src_valid !== 1'b0) $display("FAIL pop1_drained got=%b exp=0", src_valid); else n_pass++;
  endtask

  task automatic test_random();
    int n_iss;
    int n_pop;
    int guard;
    n_iss = 0;
    n_pop = 0;
    guard = 0;
    while (n_iss < N_RAND && guard < 60000) begin
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (pipe_issue === 1'b1) n_iss++;
      if (src_valid === 1'b1 && src_ready === 1'b1) n_pop++;
      guard++;
    end
    n_checks++; if (n_iss != N_RAND) $display("FAIL rand_issued got=%0d exp=%0d", n_iss, N_RAND); else n_pass++;
    guard = 0;
    while ((src_valid === 1'b1 || n_pop < n_iss) && guard < 500) begin
      tick(1'b0, 1'b1);
      if (src_valid === 1'b1) n_pop++;
      guard++;
    end
    n_checks++; if (n_pop != n_iss) $display("FAIL rand_popped got=%0d exp=%0d", n_pop, n_iss); else n_pass++;
    n_checks++; if (snk_ready !== 1'b1) $display("FAIL rand_end_ready got=%b exp=1", snk_ready); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int n_stale;
    tick(1'b0, 1'b0);
    for (int k = 0; k < 3; k++) tick(1'b1, 1'b0);
    for (int k = 0; k < LATENCY + 2; k++) tick(1'b0, 1'b0);
    for (int k = 0; k < 5; k++) tick(1'b1, 1'b0);
    n_checks++; if (src_valid !== 1'b1) $display("FAIL rmid_pre_valid got=%b exp=1", src_valid); else n_pass++;
    @(posedge clk);
    #2;
    rst = 1'b1;
    snk_valid = 1'b0;
    #1;
    n_checks++; if (src_valid !== 1'b0) $display("FAIL rmid_valid got=%b exp=0", src_valid); else n_pass++;
    n_checks++; if (snk_ready !== 1'b1) $display("FAIL rmid_ready got=%b exp=1", snk_ready); else n_pass++;
    n_checks++; if (src_data !== '0) $display("FAIL rmid_data got=%h exp=0", src_data); else n_pass++;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    src_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (snk_ready !== 1'b1) $display("FAIL rmid_release_ready got=%b exp=1", snk_ready); else n_pass++;
    n_stale = 0;
    for (int k = 0; k < 20; k++) begin
      tick(1'b0, 1'b1);
      if (src_valid !== 1'b0) n_stale++;
    end
    n_checks++; if (n_stale != 0) $display("FAIL rmid_stale got=%0d exp=0", n_stale); else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fill();
    test_pop_one();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
